// File: rtl/second_chance_victim_select.sv
// Second-chance (clock-hand) victim selector for one table bucket: one reference bit per way,
// a rotating hand, and a valid/ready handshake that hands out the chosen victim way.
module second_chance_victim_select #(
  parameter int WAYS = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit_valid_i,
  input  logic [WAY_W-1:0] hit_way_i,
  input  logic             insert_valid_i,
  output logic             insert_ready_o,
  output logic             victim_valid_o,
  output logic [WAY_W-1:0] victim_way_o,
  input  logic             victim_ready_i,
  output logic [WAYS-1:0]  ref_bits_o,
  output logic [WAY_W-1:0] hand_o,
  output logic [1:0]       state_o
);

  // Handshakes: insert is accepted on an edge where insert_valid_i && insert_ready_o;
  // the victim transfers on an edge where victim_valid_o && victim_ready_i. Valid, once
  // raised, stays high with a stable way until that transfer.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WAY_W:0]   WAYS_L   = (WAY_W+1)'(WAYS);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  logic [1:0]       state_q, state_d;
  logic [WAYS-1:0]  ref_q, ref_d;
  logic [WAY_W-1:0] hand_q, hand_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAYS-1:0]  hit_mask;
  logic [WAY_W-1:0] hand_next;
  logic             hit_in_range;

  // Out-of-range hit indices only exist when WAYS is not a power of two.
  assign hit_in_range = ({1'b0, hit_way_i} < WAYS_L);

  always_comb begin
    hit_mask = '0;
    for (int i = 0; i < WAYS; i++) begin
      hit_mask[i] = hit_valid_i && hit_in_range && (hit_way_i == WAY_W'(i));
    end
  end

  assign hand_next = (hand_q == LAST_WAY) ? '0 : hand_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    hand_d   = hand_q;
    victim_d = victim_q;
    case (state_q)
      ST_IDLE: begin
        if (insert_valid_i) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        hand_d = hand_next;
        if (ref_q[hand_q]) begin
          ref_d[hand_q] = 1'b0;
        end else begin
          ref_d[hand_q] = 1'b1;
          victim_d      = hand_q;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (victim_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A concurrent hit always wins over a scan clear; the scan decision above used ref_q.
    ref_d = ref_d | hit_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ref_q    <= '0;
      hand_q   <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      hand_q   <= hand_d;
      victim_q <= victim_d;
    end
  end

  assign insert_ready_o = (state_q == ST_IDLE);
  assign victim_valid_o = (state_q == ST_DONE);
  assign victim_way_o   = victim_q;
  assign ref_bits_o     = ref_q;
  assign hand_o         = hand_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_second_chance_victim_select.sv
// Directed bench for second_chance_victim_select (WAYS=4) with hand-computed expectations.
module tb_second_chance_victim_select;

  localparam int WAYS  = 4;
  localparam int WAY_W = 2;

  logic             clk;
  logic             reset;
  logic             hit_valid_i;
  logic [WAY_W-1:0] hit_way_i;
  logic             insert_valid_i;
  logic             insert_ready_o;
  logic             victim_valid_o;
  logic [WAY_W-1:0] victim_way_o;
  logic             victim_ready_i;
  logic [WAYS-1:0]  ref_bits_o;
  logic [WAY_W-1:0] hand_o;
  logic [1:0]       state_o;

  int checks;
  int errors;

  second_chance_victim_select #(.WAYS(WAYS)) dut (
    .clk            (clk),
    .reset          (reset),
    .hit_valid_i    (hit_valid_i),
    .hit_way_i      (hit_way_i),
    .insert_valid_i (insert_valid_i),
    .insert_ready_o (insert_ready_o),
    .victim_valid_o (victim_valid_o),
    .victim_way_o   (victim_way_o),
    .victim_ready_i (victim_ready_i),
    .ref_bits_o     (ref_bits_o),
    .hand_o         (hand_o),
    .state_o        (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [WAY_W-1:0] way);
    hit_valid_i = 1'b1;
    hit_way_i   = way;
    step();
    hit_valid_i = 1'b0;
  endtask

  task automatic insert_accept();
    insert_valid_i = 1'b1;
    step();
    insert_valid_i = 1'b0;
  endtask

  task automatic wait_victim(output int lat);
    lat = 0;
    while (!victim_valid_o && lat < 20) begin
      step();
      lat++;
    end
    if (!victim_valid_o) check("victim_timeout", 32'(victim_valid_o), 32'd1);
  endtask

  task automatic take_victim();
    victim_ready_i = 1'b1;
    step();
    victim_ready_i = 1'b0;
    check("handshake_valid_drop", 32'(victim_valid_o), 32'd0);
    check("handshake_ready_back", 32'(insert_ready_o), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ref"},   32'(ref_bits_o),     32'h0);
    check({tag, "_hand"},  32'(hand_o),         32'd0);
    check({tag, "_ready"}, 32'(insert_ready_o), 32'd1);
    check({tag, "_valid"}, 32'(victim_valid_o), 32'd0);
    check({tag, "_way"},   32'(victim_way_o),   32'd0);
    check({tag, "_state"}, 32'(state_o),        32'd0);
  endtask

  initial begin
    int lat;
    checks = 0;
    errors = 0;
    reset          = 1'b0;
    hit_valid_i    = 1'b0;
    hit_way_i      = '0;
    insert_valid_i = 1'b0;
    victim_ready_i = 1'b0;

    // 1: reset held for two cycles
    step();
    step();
    check_reset_values("reset");
    reset = 1'b1;
    step();

    // 2: empty bucket, way 0 picked after one SCAN cycle
    insert_accept();
    check("t2_scan_not_ready", 32'(insert_ready_o), 32'd0);
    wait_victim(lat);
    check("t2_latency", 32'(lat), 32'd1);
    check("t2_way",  32'(victim_way_o), 32'd0);
    check("t2_ref",  32'(ref_bits_o),   32'b0001);
    check("t2_hand", 32'(hand_o),       32'd1);
    take_victim();

    // 3: hits on 2,3,0 leave way 1 as the only clear bit at the hand
    hit(2'd2);
    hit(2'd3);
    hit(2'd0);
    check("t3_ref_pre", 32'(ref_bits_o), 32'b1101);
    insert_accept();
    wait_victim(lat);
    check("t3_latency", 32'(lat), 32'd1);
    check("t3_way",  32'(victim_way_o), 32'd1);
    check("t3_ref",  32'(ref_bits_o),   32'b1111);
    check("t3_hand", 32'(hand_o),       32'd2);
    take_victim();

    // 4: all bits set, full lap of clears then way 2 reused
    insert_accept();
    wait_victim(lat);
    check("t4_latency", 32'(lat), 32'd5);
    check("t4_way",  32'(victim_way_o), 32'd2);
    check("t4_ref",  32'(ref_bits_o),   32'b0100);
    check("t4_hand", 32'(hand_o),       32'd3);

    // 5: stall the consumer while insert_valid_i pulses
    for (int i = 0; i < 3; i++) begin
      insert_valid_i = (i != 1);
      step();
      check("t5_valid", 32'(victim_valid_o), 32'd1);
      check("t5_way",   32'(victim_way_o),   32'd2);
      check("t5_ready", 32'(insert_ready_o), 32'd0);
      check("t5_hand",  32'(hand_o),         32'd3);
      check("t5_ref",   32'(ref_bits_o),     32'b0100);
    end
    insert_valid_i = 1'b0;
    take_victim();
    check("t5_no_rescan", 32'(hand_o), 32'd3);

    // 6: hit on the hand way during its clear, then reset mid-SCAN
    hit(2'd0);
    hit(2'd1);
    hit(2'd3);
    check("t6_ref_pre", 32'(ref_bits_o), 32'b1111);
    insert_accept();
    hit_valid_i = 1'b1;
    hit_way_i   = 2'd3;
    step();
    hit_valid_i = 1'b0;
    check("t6_hit_wins", 32'(ref_bits_o), 32'b1111);
    check("t6_hand",     32'(hand_o),     32'd0);
    check("t6_scanning", 32'(state_o),    32'd1);
    step();
    check("t6_clear0",   32'(ref_bits_o), 32'b1110);
    check("t6_hand1",    32'(hand_o),     32'd1);
    reset = 1'b0;
    #1;
    check_reset_values("t6_async_reset");
    step();
    check_reset_values("t6_reset_held");
    reset = 1'b1;
    step();
    insert_accept();
    wait_victim(lat);
    check("t6_post_latency", 32'(lat), 32'd1);
    check("t6_post_way",  32'(victim_way_o), 32'd0);
    check("t6_post_hand", 32'(hand_o),       32'd1);
    check("t6_post_ref",  32'(ref_bits_o),   32'b0001);
    take_victim();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
